// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the packet SRAM free-page manager.
package sram_pkg;

   localparam int unsigned ADDRESS_WIDTH = 12;
   localparam int unsigned NUM_PAGES     = 2 ** ADDRESS_WIDTH;
   localparam int unsigned AE_THRESH     = 16;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/free_addr_mgr_if.sv
// Allocate/release/status bundle between free_addr_mgr (slave) and the write/read paths (master).
interface free_addr_mgr_if #(
   parameter int unsigned address_width = sram_pkg::ADDRESS_WIDTH
) ();

   logic                     alloc_req;
   logic                     alloc_vld;
   logic [address_width-1:0] alloc_addr;
   logic                     rel_vld;
   logic [address_width-1:0] rel_addr;
   logic [address_width:0]   free_cnt;
   logic                     almost_empty;
   logic                     init_done;
   logic                     err;

   modport master (
      output alloc_req, rel_vld, rel_addr,
      input  alloc_vld, alloc_addr, free_cnt, almost_empty, init_done, err
   );

   modport slave (
      input  alloc_req, rel_vld, rel_addr,
      output alloc_vld, alloc_addr, free_cnt, almost_empty, init_done, err
   );

endinterface

// File: rtl/free_list_ram.sv
// Free-list storage: one synchronous write port, one asynchronous read port.
module free_list_ram #(
   parameter int unsigned address_width = sram_pkg::ADDRESS_WIDTH,
   parameter int unsigned depth         = sram_pkg::NUM_PAGES
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [address_width-1:0] waddr,
   input  logic [address_width-1:0] wdata,
   input  logic [address_width-1:0] raddr,
   output logic [address_width-1:0] rdata
);

   logic [address_width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/free_addr_mgr.sv
// Free-page list manager: INIT fills the list with 0..NUM_PAGES-1, RUN pops/pushes page addresses.
// Optional FREE_ADDR_OWN_CHECK_EN adds an ownership bitmap that rejects double/foreign frees.
module free_addr_mgr #(
   parameter int unsigned address_width = sram_pkg::ADDRESS_WIDTH,
   parameter int unsigned ae_thresh     = sram_pkg::AE_THRESH
) (
   input logic            clk,
   input logic            rst,
   free_addr_mgr_if.slave bus
);
   import sram_pkg::*;

   localparam int unsigned            num_pages = 2 ** address_width;
   localparam logic [address_width:0] full_cnt  = (address_width + 1)'(num_pages);

   state_e                   state_q, state_d;
   logic [address_width-1:0] init_cnt_q, init_cnt_d;
   logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
   logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
   logic [address_width:0]   free_cnt_q, free_cnt_d;
   logic                     err_q, err_d;

   logic                     run, init_last, avail, full, pop, push, own_ok;
   logic                     ram_we;
   logic [address_width-1:0] ram_waddr, ram_wdata, ram_rdata;

   free_list_ram #(
      .address_width (address_width),
      .depth         (num_pages)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && init_last) state_d = ST_RUN;
   end

   // FSM: outputs
   always_comb begin
      bus.init_done    = run;
      bus.alloc_vld    = run & avail;
      bus.alloc_addr   = run ? ram_rdata : '0;
      bus.free_cnt     = free_cnt_q;
      bus.almost_empty = 32'(free_cnt_q) <= ae_thresh;
      bus.err          = err_q;
   end

`ifdef FREE_ADDR_OWN_CHECK_EN
   logic [num_pages-1:0] own_q, own_d;

   // A page popped this cycle may legally come straight back in the same cycle.
   assign own_ok = own_q[bus.rel_addr] | (pop & (ram_rdata == bus.rel_addr));

   always_comb begin
      own_d = own_q;
      if (pop)  own_d[ram_rdata]    = 1'b1;
      if (push) own_d[bus.rel_addr] = 1'b0;
      if (!run) own_d               = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) own_q <= '0;
      else     own_q <= own_d;
   end
`else
   assign own_ok = 1'b1;
`endif

   always_comb begin
      run       = state_q == ST_RUN;
      init_last = init_cnt_q == '1;
      avail     = free_cnt_q != '0;
      full      = free_cnt_q == full_cnt;
      pop       = run & bus.alloc_req & avail;
      // When full, a release is only room-safe if a pop frees a slot in the same cycle.
      push      = run & bus.rel_vld & (~full | pop) & own_ok;

      init_cnt_d = init_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      free_cnt_d = free_cnt_q;
      err_d      = err_q;
      ram_we     = push;
      ram_waddr  = wr_ptr_q;
      ram_wdata  = bus.rel_addr;

      if (!run) begin
         init_cnt_d = init_cnt_q + address_width'(1);
         free_cnt_d = free_cnt_q + (address_width + 1)'(1);
         err_d      = err_q | bus.alloc_req | bus.rel_vld;
         ram_we     = 1'b1;
         ram_waddr  = init_cnt_q;
         ram_wdata  = init_cnt_q;
      end else begin
         rd_ptr_d   = rd_ptr_q + address_width'(pop);
         wr_ptr_d   = wr_ptr_q + address_width'(push);
         free_cnt_d = free_cnt_q + (address_width + 1)'(push) - (address_width + 1)'(pop);
         err_d      = err_q | (bus.alloc_req & ~avail) | (bus.rel_vld & ~push);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         free_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         init_cnt_q <= init_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         free_cnt_q <= free_cnt_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_free_addr_mgr.sv
// Scoreboard bench for free_addr_mgr: a queue-based free-list model predicts every cycle's outputs.
module tb_free_addr_mgr;

   localparam int AW = 4;
   localparam int NP = 16;
   localparam int AE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   free_addr_mgr_if #(.address_width(AW)) bus ();

   free_addr_mgr #(
      .address_width (AW),
      .ae_thresh     (AE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit    vld;
      int    addr;
      int    cnt;
      bit    ae;
      bit    done;
      bit    err;
      string tag;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model: the free list is literally a FIFO of page numbers.
   bit m_known = 1'b0;
   bit m_init;
   int m_init_cnt;
   int m_q[$];
   bit m_own[NP];
   bit m_err;
   int alloc_hist[$];

   function automatic exp_t cur_exp(string tag);
      exp_t e;
      e.tag  = tag;
      e.done = !m_init;
      e.cnt  = m_init ? m_init_cnt : m_q.size();
      e.vld  = !m_init && (m_q.size() > 0);
      e.addr = e.vld ? m_q[0] : 0;
      e.ae   = e.cnt <= AE;
      e.err  = m_err;
      return e;
   endfunction

   task automatic model_update(bit r, bit req, bit rel, int ra);
      if (r) begin
         m_known    = 1'b1;
         m_init     = 1'b1;
         m_init_cnt = 0;
         m_q.delete();
         m_err      = 1'b0;
         for (int i = 0; i < NP; i++) m_own[i] = 1'b0;
         alloc_hist.delete();
      end else if (m_known && m_init) begin
         m_init_cnt++;
         if (req || rel) m_err = 1'b1;
         if (m_init_cnt == NP) begin
            m_init = 1'b0;
            for (int i = 0; i < NP; i++) m_q.push_back(i);
         end
      end else if (m_known) begin
         bit vld = m_q.size() != 0;
         bit pop = req && vld;
         int a   = vld ? m_q[0] : 0;
         bit ok  = rel && (m_q.size() < NP || pop);
`ifdef FREE_ADDR_OWN_CHECK_EN
         ok = ok && (m_own[ra] || (pop && a == ra));
`endif
         if (pop) begin
            void'(m_q.pop_front());
            m_own[a] = 1'b1;
            alloc_hist.push_back(a);
         end
         if (ok) begin
            int idx[$];
            m_q.push_back(ra);
            m_own[ra] = 1'b0;
            idx = alloc_hist.find_first_index(x) with (x == ra);
            if (idx.size() > 0) alloc_hist.delete(idx[0]);
         end
         if (req && !vld) m_err = 1'b1;
         if (rel && !ok)  m_err = 1'b1;
      end
   endtask

   task automatic step(bit r, bit req, bit rel, int ra, string tag);
      logic [31:0] ra_v;
      if (m_known) expq.push_back(cur_exp(tag));
      ra_v          = ra;
      rst           = r;
      bus.alloc_req = req;
      bus.rel_vld   = rel;
      bus.rel_addr  = ra_v[AW-1:0];
      @(posedge clk);
      model_update(r, req, rel, ra);
      #1;
   endtask

   task automatic idle(int n, string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, tag);
   endtask

   task automatic chk(string tag, string name, logic [31:0] act, int exp);
      checks++;
      if (act !== exp) $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
      else passes++;
   endtask

   // Monitor: every cycle with a prediction queued, compare the visible outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk(e.tag, "alloc_vld", 32'(bus.alloc_vld), int'(e.vld));
            if (e.vld) chk(e.tag, "alloc_addr", 32'(bus.alloc_addr), e.addr);
            chk(e.tag, "free_cnt", 32'(bus.free_cnt), e.cnt);
            chk(e.tag, "almost_empty", 32'(bus.almost_empty), int'(e.ae));
            chk(e.tag, "init_done", 32'(bus.init_done), int'(e.done));
            chk(e.tag, "err", 32'(bus.err), int'(e.err));
         end
      end
   end

   initial begin
      int preq, prel, ra;
      bus.alloc_req = 1'b0;
      bus.rel_vld   = 1'b0;
      bus.rel_addr  = '0;

      step(1'b1, 1'b0, 1'b0, 0, "reset");
      step(1'b1, 1'b0, 1'b0, 0, "reset");
      idle(16, "init");
      idle(1, "post_init");

      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 0, "drain");
      step(1'b0, 1'b1, 1'b0, 0, "alloc_empty");
      idle(1, "empty_err");

      step(1'b0, 1'b1, 1'b1, 9, "rel_empty");
      idle(1, "rel_visible");

      step(1'b1, 1'b0, 1'b0, 0, "reset2");
      idle(16, "init2");
      step(1'b0, 1'b0, 1'b1, 5, "rel_full");
      step(1'b0, 1'b1, 1'b1, 0, "swap_full");
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 0, "wrap_pop");
      idle(1, "wrap_head");

      step(1'b1, 1'b0, 1'b0, 0, "reset3");
      idle(7, "init_part");
      step(1'b1, 1'b0, 1'b0, 0, "reset_mid");
      idle(16, "reinit");
      idle(1, "reinit_done");

      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, "pre_pop");
      step(1'b0, 1'b1, 1'b0, 0, "alloc3");
      step(1'b0, 1'b0, 1'b1, 3, "rel3_a");
      step(1'b0, 1'b0, 1'b1, 3, "rel3_b");
      idle(1, "rel3_after");

      for (int blk = 0; blk < 15; blk++) begin
         preq = $urandom_range(10, 90);
         prel = $urandom_range(10, 90);
         for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 499) == 0) begin
               step(1'b1, 1'b0, 1'b0, 0, "rand_rst");
            end else begin
               if (alloc_hist.size() > 0 && $urandom_range(0, 3) != 0)
                  ra = alloc_hist[$urandom_range(0, alloc_hist.size() - 1)];
               else
                  ra = $urandom_range(0, NP - 1);
               step(1'b0, $urandom_range(0, 99) < preq, $urandom_range(0, 99) < prel, ra,
                    "random");
            end
         end
      end

      idle(2, "tail");
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/free_addr_mgr.md
Name: free_addr_mgr

Overview:
Free-page list manager for the shared packet SRAM. Supplies one free page address per cycle to the write path, where datasg consumes it as address_in. Recycles addresses that the read path releases once a page has been fully read out. Reports occupancy so the write arbiter can stop admitting packets before the SRAM runs out.

Parameters:
address_width, 12, width of one SRAM page address; NUM_PAGES = 2**address_width
ae_thresh, 16, almost_empty asserts when free_cnt <= ae_thresh
init_cycles_per_entry, 1, fixed; one list entry is initialised per clock (documentary only, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
alloc_req  input  1  write path consumes alloc_addr this cycle
alloc_vld  output  1  alloc_addr is a valid free page
alloc_addr  output  address_width  head of free list
rel_vld  input  1  read path returns rel_addr to the list
rel_addr  input  address_width  page being freed
free_cnt  output  address_width+1  number of free pages, 0..NUM_PAGES
almost_empty  output  1  free_cnt <= ae_thresh
init_done  output  1  list initialisation complete
err  output  1  sticky: illegal release or alloc seen

Behaviour:
- Storage: circular list of NUM_PAGES entries, each address_width wide, with combinational read at rd_ptr. rd_ptr and wr_ptr are address_width wide and wrap naturally from NUM_PAGES-1 to 0.
- States: INIT and RUN.
- Reset (rst=1 at posedge): state goes to INIT. init_cnt, rd_ptr, wr_ptr, free_cnt and err all clear to 0; init_done=0, alloc_vld=0, alloc_addr=0, almost_empty=1.
- rst has priority over everything, including mid-INIT and mid-RUN; the list is rebuilt from scratch.
- INIT: each cycle writes mem[init_cnt] <= init_cnt and increments free_cnt. On the cycle init_cnt==NUM_PAGES-1 the block moves to RUN, with free_cnt=NUM_PAGES, wr_ptr=0 (wrapped) and rd_ptr=0. INIT lasts exactly NUM_PAGES cycles.
- Inputs during INIT: alloc_req and rel_vld are ignored; either one sets err.
- RUN outputs:
  - init_done=1
  - alloc_vld = (free_cnt != 0)
  - alloc_addr = mem[rd_ptr], combinational from registered state
  - almost_empty = (free_cnt <= ae_thresh), combinational
- Allocate: alloc_req & alloc_vld pops the entry (rd_ptr+1) and the address leaves the list. Zero-latency handshake: the address is valid in the same cycle as the request.
- alloc_req while alloc_vld=0 (empty): no pop, set err.
- Release: rel_vld pushes (mem[wr_ptr] <= rel_addr, wr_ptr+1).
- rel_vld when free_cnt==NUM_PAGES (full): dropped, set err.
- Simultaneous allocate and release:
  - Both take effect and free_cnt is unchanged.
  - If free_cnt==0 at that moment, alloc_vld=0, so only the release happens. The released address is visible on alloc_addr the next cycle, never the same cycle (no bypass).
- free_cnt next value = free_cnt + push - pop; it never wraps.
- err is sticky until rst.

Optional Feature:
FREE_ADDR_OWN_CHECK_EN
- Defined:
  - Adds a NUM_PAGES-bit ownership bitmap: the bit sets on allocate and clears on release. All bits are clear at the end of INIT.
  - A release whose bit is clear (double free, or a never-allocated page) is dropped: no push, and err is set.
  - A same-cycle allocate and release of the same address is legal; that release is accepted.
- Undefined: no bitmap. Every in-range release while not full is accepted.

Decomposition:
- Shared package sram_pkg holds:
  - ADDRESS_WIDTH = 12
  - NUM_PAGES
  - the state encoding (ST_INIT=1'b0, ST_RUN=1'b1)
  - the default AE_THRESH
- One sub-module: free_list_ram. It is an NUM_PAGES x address_width array with one synchronous write port and one asynchronous read port, instantiated once.
- Pointers, counters, FSM and the checker stay in free_addr_mgr.

Test Plan:
Tests use address_width=4 (NUM_PAGES=16) and ae_thresh=2.
1. Release rst after 2 cycles -> init_done rises exactly 16 cycles later; then free_cnt=16, alloc_vld=1, alloc_addr=0, err=0.
2. Hold alloc_req for 16 cycles -> alloc_addr sequence is 0..15; almost_empty rises when free_cnt=2; after the 16th pop alloc_vld=0; a 17th alloc_req sets err=1.
3. From empty, rel_vld with rel_addr=9 and alloc_req in the same cycle -> no pop; next cycle alloc_vld=1, alloc_addr=9, free_cnt=1.
4. From full, release 5 -> dropped, free_cnt stays 16, err=1. Then allocate 0 and release 0 in the same cycle -> free_cnt stays 16, and after 15 further pops alloc_addr=0 again (wrap).
5. Pulse rst mid-INIT at init_cnt=7 -> free_cnt=0 and init_done=0 the next cycle; re-init takes a full 16 cycles.
6. With FREE_ADDR_OWN_CHECK_EN: allocate 3, release 3, release 3 -> the second release is dropped, free_cnt is unchanged by it, err=1.
